// File: rtl/multiplier_arbiter_if.sv
// multiplier_arbiter_if
// Bundles every signal between multiplier_arbiter, its requesters and the
// shared sequential multiplier. clk and rst stay plain ports of the arbiter.
//
// Signals:
//   req_vld/req_rdy   per-requester operand handshake
//   req_a/req_b       packed operands, requester k uses bits [8k+7:8k]
//   rsp_vld/rsp_rdy   per-requester result handshake
//   rsp_res           16-bit product shared by all requesters
//   busy, owner       arbiter status
//   mul_in_a/b/vld    load port of the multiplier
//   mul_res/_rdy      product and done/idle flag from the multiplier
//
// Modports:
//   master  requester and multiplier side (drives requests and multiplier results)
//   slave   the arbiter itself
interface multiplier_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_vld;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   rsp_vld;
    logic [NUM_REQ-1:0]   rsp_rdy;
    logic [15:0]          rsp_res;
    logic                 busy;
    logic [ID_W-1:0]      owner;
    logic [7:0]           mul_in_a;
    logic [7:0]           mul_in_b;
    logic                 mul_in_vld;
    logic [15:0]          mul_res;
    logic                 mul_res_rdy;

    modport master (
        output req_vld, req_a, req_b, rsp_rdy, mul_res, mul_res_rdy,
        input  req_rdy, rsp_vld, rsp_res, busy, owner,
               mul_in_a, mul_in_b, mul_in_vld
    );

    modport slave (
        input  req_vld, req_a, req_b, rsp_rdy, mul_res, mul_res_rdy,
        output req_rdy, rsp_vld, rsp_res, busy, owner,
               mul_in_a, mul_in_b, mul_in_vld
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter
// Round-robin controller sharing one 8x8 sequential shift-add multiplier
// among NUM_REQ requesters. Operands arrive on per-requester valid/ready
// handshakes, the multiplier is driven with a one-cycle load strobe, and the
// 16-bit product is returned on the owning requester's response handshake.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   multiplier_arbiter_if.slave carrying the request, response,
//         status and multiplier signals
//
// Optional feature macro: MULTIPLIER_ARBITER_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips the multiplier and is
//   answered with 0 in the cycle after the grant. When undefined, every
//   request goes through the multiplier.
module multiplier_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    multiplier_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] owner_d;
    logic [7:0]      opA_q;
    logic [7:0]      opA_d;
    logic [7:0]      opB_q;
    logic [7:0]      opB_d;
    logic [15:0]     res_q;
    logic [15:0]     res_d;

    logic            grantValid;
    logic [ID_W-1:0] grantIdx;
    logic [ID_W-1:0] candIdx;
    logic [7:0]      selA;
    logic [7:0]      selB;
    logic            accept;
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
    logic            zeroOp;
`endif

    // Round-robin search starting one past the last owner and wrapping, so the
    // most recently served requester always has the lowest priority.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = owner_q;
        candIdx    = owner_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            candIdx = ID_W'((int'(owner_q) + i) % NUM_REQ);
            if (!grantValid && bus.req_vld[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // A grant needs an idle multiplier, because one left running by a reset
    // would otherwise be reloaded mid-operation. rst gates the handshake so
    // req_rdy stays low while reset is held.
    always_comb begin
        accept = rst && (state_q == IDLE) && grantValid && bus.mul_res_rdy;
        selA   = bus.req_a[int'(grantIdx)*8 +: 8];
        selB   = bus.req_b[int'(grantIdx)*8 +: 8];
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
        zeroOp = (selA == 8'h00) || (selB == 8'h00);
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. WAIT never sees mul_res_rdy high in its first cycle
    // because the multiplier drops its done flag when loaded in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
                    state_d = zeroOp ? RESP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mul_res_rdy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_rdy[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: operands and owner are captured on the grant, the
    // product when the multiplier reports done. Outside those two events the
    // result register holds, which keeps rsp_res stable throughout RESP.
    always_comb begin
        owner_d = owner_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        if (accept) begin
            owner_d = grantIdx;
            opA_d   = selA;
            opB_d   = selB;
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
            if (zeroOp) begin
                res_d = 16'h0000;
            end
`endif
        end
        if ((state_q == WAIT) && bus.mul_res_rdy) begin
            res_d = bus.mul_res;
        end
    end

    // Datapath registers. owner resets to the last index so requester 0 is
    // first in line after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= ID_W'(NUM_REQ - 1);
            opA_q   <= 8'h00;
            opB_q   <= 8'h00;
            res_q   <= 16'h0000;
        end else begin
            owner_q <= owner_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            res_q   <= res_d;
        end
    end

    // Outputs: handshake strobes are one-hot on the granted or owning index.
    always_comb begin
        bus.req_rdy = '0;
        bus.rsp_vld = '0;
        if (accept) begin
            bus.req_rdy[grantIdx] = 1'b1;
        end
        if (state_q == RESP) begin
            bus.rsp_vld[owner_q] = 1'b1;
        end
        bus.rsp_res    = res_q;
        bus.busy       = (state_q != IDLE);
        bus.owner      = owner_q;
        bus.mul_in_a   = opA_q;
        bus.mul_in_b   = opB_q;
        bus.mul_in_vld = (state_q == ISSUE);
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
`timescale 1ns/1ps
// tb_multiplier_arbiter
// Drives multiplier_arbiter with directed and random requests, models the
// shared sequential multiplier, and compares every grant and response with
// a request-level reference model of the arbitration and timing rules.
module tb_multiplier_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    int   lastOwner = NUM_REQ - 1;

    logic [7:0]  opA [NUM_REQ];
    logic [7:0]  opB [NUM_REQ];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    multiplier_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    multiplier_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sequential multiplier model: load clears done, eight step cycles,
    // done and the product appear afterwards. It is not reset by rst and
    // shows garbage on its result while stepping.
    logic        mulRdy  = 1'b1;
    logic [15:0] mulRes  = 16'h0000;
    logic [15:0] mulProd = 16'h0000;
    int          mulCnt  = 0;

    assign bus.mul_res_rdy = mulRdy;
    assign bus.mul_res     = mulRes;

    always @(posedge clk) begin
        if (bus.mul_in_vld) begin
            mulCnt  <= 8;
            mulRdy  <= 1'b0;
            mulProd <= 16'(bus.mul_in_a) * 16'(bus.mul_in_b);
            mulRes  <= 16'($urandom);
        end else if (mulCnt > 0) begin
            mulCnt <= mulCnt - 1;
            if (mulCnt == 1) begin
                mulRdy <= 1'b1;
                mulRes <= mulProd;
            end else begin
                mulRes <= 16'($urandom);
            end
        end
    end

    // Reference rules: round-robin pick after the last owner, and latency
    // from grant to response.
    function automatic int rrPick(input int last, input logic [NUM_REQ-1:0] mask);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = (last + i) % NUM_REQ;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] oneHotOf(input int k);
        oneHotOf = '0;
        if (k >= 0) oneHotOf[k] = 1'b1;
    endfunction

    function automatic int latencyOf(input logic [7:0] a, input logic [7:0] b);
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
        if (a == 8'h00 || b == 8'h00) return 1;
`endif
        return 11;
    endfunction

    task automatic setOperands(input int k, input logic [7:0] a, input logic [7:0] b);
        opA[k] = a;
        opB[k] = b;
        bus.req_a[k*8 +: 8] = a;
        bus.req_b[k*8 +: 8] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req_vld = '1;
        bus.rsp_rdy = '0;
        for (int k = 0; k < NUM_REQ; k++) setOperands(k, 8'($urandom), 8'($urandom));
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.req_rdy !== '0 || bus.rsp_vld !== '0) begin
            bad++;
            $display("[TB] FAIL reset_handshake: req_rdy=%b rsp_vld=%b required 0000/0000", bus.req_rdy, bus.rsp_vld);
        end
        total++;
        if (bus.rsp_res !== 16'h0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_status: rsp_res=%h busy=%b required 0000/0", bus.rsp_res, bus.busy);
        end
        total++;
        if (bus.owner !== ID_W'(NUM_REQ - 1)) begin
            bad++;
            $display("[TB] FAIL reset_owner: owner=%0d required %0d", bus.owner, NUM_REQ - 1);
        end
        total++;
        if (bus.mul_in_a !== 8'h00 || bus.mul_in_b !== 8'h00 || bus.mul_in_vld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mul: a=%h b=%h vld=%b required 00/00/0", bus.mul_in_a, bus.mul_in_b, bus.mul_in_vld);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req_vld = '0;
        lastOwner = NUM_REQ - 1;
        #1;
    endtask

    task automatic test_single_request(input int k, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [15:0]        expRes;
        logic [NUM_REQ-1:0] oneHot;
        int                 expLat;
        int                 waitCnt;
        bit                 bypass;
        bit                 early;
        bit                 unstable;
        expRes   = 16'(a) * 16'(b);
        oneHot   = oneHotOf(k);
        expLat   = latencyOf(a, b);
        bypass   = (expLat == 1);
        early    = 1'b0;
        unstable = 1'b0;
        @(negedge clk);
        setOperands(k, a, b);
        bus.req_vld = oneHot;
        bus.rsp_rdy = '0;
        #1;
        waitCnt = 0;
        while (bus.req_rdy === '0 && waitCnt < 40) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        total++;
        if (bus.req_rdy !== oneHot) begin
            bad++;
            $display("[TB] FAIL single_grant k=%0d: req_rdy=%b required %b", k, bus.req_rdy, oneHot);
        end
        lastOwner = k;
        for (int c = 1; c <= expLat; c++) begin
            @(negedge clk);
            bus.req_vld = '0;
            #1;
            if (c == 1) begin
                total++;
                if (bus.mul_in_vld !== !bypass || (!bypass && (bus.mul_in_a !== a || bus.mul_in_b !== b))) begin
                    bad++;
                    $display("[TB] FAIL single_issue k=%0d: vld=%b a=%h b=%h required vld=%b a=%h b=%h",
                             k, bus.mul_in_vld, bus.mul_in_a, bus.mul_in_b, !bypass, a, b);
                end
            end else if (bus.mul_in_vld !== 1'b0) begin
                early = 1'b1;
            end
            if (c < expLat && bus.rsp_vld !== '0) early = 1'b1;
            if (bus.req_rdy !== '0 || bus.busy !== 1'b1) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("[TB] FAIL single_latency k=%0d: early response, stray strobe or idle before T+%0d", k, expLat);
        end
        total++;
        if (bus.rsp_vld !== oneHot || bus.rsp_res !== expRes || bus.owner !== ID_W'(k)) begin
            bad++;
            $display("[TB] FAIL single_result k=%0d: rsp_vld=%b rsp_res=%0d owner=%0d required %b/%0d/%0d",
                     k, bus.rsp_vld, bus.rsp_res, bus.owner, oneHot, expRes, k);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.rsp_rdy = ~oneHot;
            bus.req_vld = ~oneHot;
            #1;
            if (bus.rsp_vld !== oneHot || bus.rsp_res !== expRes || bus.req_rdy !== '0) unstable = 1'b1;
        end
        if (hold > 0) begin
            total++;
            if (unstable) begin
                bad++;
                $display("[TB] FAIL single_hold k=%0d: response moved or grant seen while rsp_rdy[%0d] low", k, k);
            end
        end
        @(negedge clk);
        bus.rsp_rdy = oneHot;
        bus.req_vld = '0;
        #1;
        total++;
        if (bus.rsp_vld !== oneHot || bus.rsp_res !== expRes) begin
            bad++;
            $display("[TB] FAIL single_accept_cycle k=%0d: rsp_vld=%b rsp_res=%0d required %b/%0d", k, bus.rsp_vld, bus.rsp_res, oneHot, expRes);
        end
        @(negedge clk);
        bus.rsp_rdy = '0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp_vld !== '0) begin
            bad++;
            $display("[TB] FAIL single_idle k=%0d: busy=%b rsp_vld=%b required 0/0000", k, bus.busy, bus.rsp_vld);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] expRes [NUM_REQ];
        logic [15:0] pendRes;
        int          pendOwner;
        int          resps;
        int          budget;
        int          expGrant;
        int          prevGrant;
        int          refreshK;
        pendRes   = 16'h0000;
        pendOwner = -1;
        resps     = 0;
        budget    = 0;
        prevGrant = -1;
        refreshK  = -1;
        @(negedge clk);
        for (int k = 0; k < NUM_REQ; k++) begin
            setOperands(k, 8'(17 * k + 3 + $urandom_range(0, 9)), 8'(40 + 31 * k));
            expRes[k] = 16'(opA[k]) * 16'(opB[k]);
        end
        bus.req_vld = '1;
        bus.rsp_rdy = '1;
        #1;
        while (resps < NUM_REQ + 1 && budget < 200) begin
            if (bus.req_rdy !== '0) begin
                expGrant = rrPick(lastOwner, bus.req_vld);
                total++;
                if (bus.req_rdy !== oneHotOf(expGrant)) begin
                    bad++;
                    $display("[TB] FAIL rr_grant: req_rdy=%b required %b", bus.req_rdy, oneHotOf(expGrant));
                end
                if (prevGrant >= 0) begin
                    total++;
                    if (cycle - prevGrant != 12) begin
                        bad++;
                        $display("[TB] FAIL rr_spacing: gap=%0d required 12", cycle - prevGrant);
                    end
                end
                prevGrant = cycle;
                pendOwner = expGrant;
                pendRes   = expRes[expGrant];
                lastOwner = expGrant;
                refreshK  = expGrant;
            end
            if (bus.rsp_vld !== '0) begin
                total++;
                if (bus.rsp_vld !== oneHotOf(pendOwner) || bus.rsp_res !== pendRes) begin
                    bad++;
                    $display("[TB] FAIL rr_resp: rsp_vld=%b rsp_res=%0d required %b/%0d",
                             bus.rsp_vld, bus.rsp_res, oneHotOf(pendOwner), pendRes);
                end
                resps++;
            end
            @(negedge clk);
            if (refreshK >= 0) begin
                setOperands(refreshK, 8'($urandom), 8'($urandom));
                expRes[refreshK] = 16'(opA[refreshK]) * 16'(opB[refreshK]);
                refreshK = -1;
            end
            #1;
            budget++;
        end
        total++;
        if (resps != NUM_REQ + 1) begin
            bad++;
            $display("[TB] FAIL rr_budget: responses=%0d required %0d", resps, NUM_REQ + 1);
        end
        bus.req_vld = '0;
        @(negedge clk);
        bus.rsp_rdy = '0;
        #1;
    endtask

    task automatic test_reset_inflight();
        logic [15:0] expRes;
        int          hsCycle;
        int          waitCnt;
        bit          stale;
        stale = 1'b0;
        @(negedge clk);
        setOperands(1, 8'd99, 8'd201);
        bus.req_vld = 4'b0010;
        bus.rsp_rdy = '0;
        #1;
        waitCnt = 0;
        while (bus.req_rdy === '0 && waitCnt < 40) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        total++;
        if (bus.req_rdy !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL rstfl_grant: req_rdy=%b required 0010", bus.req_rdy);
        end
        hsCycle = cycle;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.req_vld = '0;
            #1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp_vld !== '0 || bus.rsp_res !== 16'h0000 || bus.mul_in_vld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstfl_status: busy=%b rsp_vld=%b rsp_res=%h mul_in_vld=%b required 0/0000/0000/0",
                     bus.busy, bus.rsp_vld, bus.rsp_res, bus.mul_in_vld);
        end
        total++;
        if (bus.owner !== ID_W'(NUM_REQ - 1) || bus.mul_in_a !== 8'h00 || bus.mul_in_b !== 8'h00) begin
            bad++;
            $display("[TB] FAIL rstfl_regs: owner=%0d a=%h b=%h required %0d/00/00", bus.owner, bus.mul_in_a, bus.mul_in_b, NUM_REQ - 1);
        end
        @(negedge clk);
        rst = 1'b1;
        lastOwner = NUM_REQ - 1;
        setOperands(3, 8'd250, 8'd7);
        expRes = 16'd1750;
        bus.req_vld = 4'b1000;
        #1;
        waitCnt = 0;
        while (bus.req_rdy === '0 && waitCnt < 40) begin
            if (bus.mul_res_rdy === 1'b1 || bus.rsp_vld !== '0) stale = 1'b1;
            @(negedge clk);
            #1;
            waitCnt++;
        end
        total++;
        if (stale || bus.req_rdy !== 4'b1000 || cycle - hsCycle != 10) begin
            bad++;
            $display("[TB] FAIL rstfl_regrant: req_rdy=%b at offset %0d stale=%b required 1000 at offset 10",
                     bus.req_rdy, cycle - hsCycle, stale);
        end
        hsCycle = cycle;
        lastOwner = 3;
        waitCnt = 0;
        @(negedge clk);
        bus.req_vld = '0;
        bus.rsp_rdy = '1;
        #1;
        while (bus.rsp_vld === '0 && waitCnt < 40) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        total++;
        if (bus.rsp_vld !== 4'b1000 || bus.rsp_res !== expRes || cycle - hsCycle != 11) begin
            bad++;
            $display("[TB] FAIL rstfl_resp: rsp_vld=%b rsp_res=%0d latency=%0d required 1000/%0d/11",
                     bus.rsp_vld, bus.rsp_res, cycle - hsCycle, expRes);
        end
        @(negedge clk);
        bus.rsp_rdy = '0;
        #1;
    endtask

    task automatic test_random();
        bit                 inFlight;
        int                 inOwner;
        int                 inLat;
        int                 grantCycle;
        int                 justGranted;
        int                 expK;
        int                 waitCnt;
        logic [15:0]        inRes;
        logic [NUM_REQ-1:0] expVld;
        inFlight    = 1'b0;
        inOwner     = 0;
        inLat       = 11;
        grantCycle  = 0;
        justGranted = -1;
        inRes       = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (justGranted >= 0) begin
                bus.req_vld[justGranted] = 1'b0;
                justGranted = -1;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!bus.req_vld[k] && $urandom_range(0, 3) == 0) begin
                    setOperands(k, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                                   ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
                    bus.req_vld[k] = 1'b1;
                end else if (bus.req_vld[k] && $urandom_range(0, 15) == 0) begin
                    bus.req_vld[k] = 1'b0;
                end
            end
            bus.rsp_rdy = NUM_REQ'($urandom);
            #1;
            if (!inFlight && bus.req_vld !== '0 && bus.mul_res_rdy === 1'b1) begin
                expK = rrPick(lastOwner, bus.req_vld);
                total++;
                if (bus.req_rdy !== oneHotOf(expK)) begin
                    bad++;
                    $display("[TB] FAIL rnd_grant: req_rdy=%b required %b", bus.req_rdy, oneHotOf(expK));
                end
                inFlight    = 1'b1;
                inOwner     = expK;
                inRes       = 16'(opA[expK]) * 16'(opB[expK]);
                inLat       = latencyOf(opA[expK], opB[expK]);
                grantCycle  = cycle;
                lastOwner   = expK;
                justGranted = expK;
            end else begin
                total++;
                if (bus.req_rdy !== '0) begin
                    bad++;
                    $display("[TB] FAIL rnd_no_grant: req_rdy=%b required 0000", bus.req_rdy);
                end
            end
            expVld = (inFlight && cycle - grantCycle >= inLat) ? oneHotOf(inOwner) : '0;
            total++;
            if (bus.rsp_vld !== expVld) begin
                bad++;
                $display("[TB] FAIL rnd_rsp_vld: rsp_vld=%b required %b", bus.rsp_vld, expVld);
            end
            if (expVld !== '0) begin
                total++;
                if (bus.rsp_res !== inRes) begin
                    bad++;
                    $display("[TB] FAIL rnd_rsp_res: rsp_res=%0d required %0d", bus.rsp_res, inRes);
                end
                if (bus.rsp_rdy[inOwner]) inFlight = 1'b0;
            end
        end
        @(negedge clk);
        bus.req_vld = '0;
        bus.rsp_rdy = '1;
        #1;
        waitCnt = 0;
        while (bus.busy !== 1'b0 && waitCnt < 40) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rnd_drain: busy=%b required 0", bus.busy);
        end
        bus.rsp_rdy = '0;
    endtask

    initial begin
        bus.req_vld = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.rsp_rdy = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            opA[k] = 8'h00;
            opB[k] = 8'h00;
        end
        test_reset();
        test_single_request(0, 8'd13, 8'd11, 0);
        test_single_request(2, 8'd255, 8'd255, 5);
        test_single_request(1, 8'd0, 8'd77, 2);
        test_single_request(3, 8'd200, 8'd3, 1);
        test_round_robin();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin controller that shares one 8x8 sequential shift-add multiplier among `NUM_REQ` requesters. It accepts operand pairs on per-requester valid/ready handshakes and sequences the multiplier's load/step/done protocol. It returns each 16-bit product on a per-requester response handshake. It sits between the requesting datapath blocks and a single `multiplier` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `ID_W`, $clog2(NUM_REQ): width of the owner index.

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_vld` in NUM_REQ: request valid, one bit per requester.
- `req_rdy` out NUM_REQ: request accepted; at most one bit high.
- `req_a` in NUM_REQ*8: operand A; requester k uses bits [8k+7:8k].
- `req_b` in NUM_REQ*8: operand B; same packing as `req_a`.
- `rsp_vld` out NUM_REQ: result valid for requester k; at most one bit high.
- `rsp_rdy` in NUM_REQ: requester k accepts its result.
- `rsp_res` out 16: product, shared by all requesters; qualified by `rsp_vld`.
- `busy` out 1: high in every state except IDLE.
- `owner` out ID_W: index of the current or last granted requester.
- `mul_in_a` out 8: multiplier operand A.
- `mul_in_b` out 8: multiplier operand B.
- `mul_in_vld` out 1: one-cycle load strobe to the multiplier.
- `mul_res` in 16: multiplier product.
- `mul_res_rdy` in 1: multiplier done/idle flag.

## Operation
State machine states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grants only when `|req_vld` and `mul_res_rdy` = 1. A multiplier still finishing an abandoned operation blocks grants.
- Round-robin arbitration: search starts at `owner`+1 and wraps modulo `NUM_REQ`.
- `req_rdy[k]` = IDLE & grant_k & `mul_res_rdy` (combinational).
- On the handshake: capture `req_a[k]`, `req_b[k]` and `owner` <= k, then go to ISSUE.

ISSUE (one cycle):
- Drive `mul_in_vld` = 1 with the captured operands, then go to WAIT.
- `mul_in_a`/`mul_in_b` hold the captured operands in all states.

WAIT:
- Stay while `mul_res_rdy` = 0.
- When `mul_res_rdy` = 1: register `mul_res` into `rsp_res`, then go to RESP.
- In the first WAIT cycle `mul_res_rdy` is always 0, because the multiplier clears its done flag on load.

RESP:
- `rsp_vld[owner]` = 1, and `rsp_res` is held stable.
- On `rsp_rdy[owner]`, go to IDLE. `rsp_rdy` on other bits is ignored.
- No new request is accepted until IDLE is reached.

Arithmetic:
- Unsigned 8x8 to 16 bits. No truncation or saturation.

Reset:
- Applies immediately in any state. Any in-flight operation is discarded without a response.
- The multiplier is not reset by this block. IDLE waits on `mul_res_rdy` before the next grant.

## Timing
- Reset values: `req_rdy`=0, `rsp_vld`=0, `rsp_res`=16'h0000, `busy`=0, `owner`=NUM_REQ-1 (so requester 0 has first priority), `mul_in_a`=8'h00, `mul_in_b`=8'h00, `mul_in_vld`=0, state IDLE.
- Request handshake in cycle T: ISSUE in T+1, multiplier steps over T+2..T+9, `mul_res_rdy` high in T+10, `rsp_vld` high in T+11.
- Minimum spacing between grants is 12 cycles, reached when `rsp_rdy` is already high in T+11.
- `rsp_vld` stays high until accepted. `rsp_res` must not change while `rsp_vld` is high.
- A requester that deasserts `req_vld` before it is granted loses nothing. The arbiter never latches a request without the handshake.
- Simultaneous requests: exactly one grant per IDLE cycle.
- All requests persistent: service order is 0,1,...,NUM_REQ-1,0,...
- `owner` wraps from NUM_REQ-1 to 0.

## Configuration
Macro `MULTIPLIER_ARBITER_ZERO_BYPASS_EN`:
- Defined: if a captured operand is 8'h00, the FSM goes from the grant directly to RESP with `rsp_res`=0. `mul_in_vld` is never pulsed, and `rsp_vld` is high in T+1.
- Undefined: every request goes through ISSUE/WAIT with the 11-cycle latency, including zero operands.

## Test plan
- Reset, then requester 0 sends a=13, b=11 in cycle T: `mul_in_vld` pulses in T+1, `rsp_vld[0]` rises in T+11 with `rsp_res`=143.
- Requester 2 sends a=255, b=255: `rsp_res`=16'hFE01 (65025).
- All 4 requesters hold `req_vld` with distinct operands (owner is 3 after reset): grants in order 0,1,2,3, then 0 again if still requesting. Each product is returned only on its own `rsp_vld` bit.
- `rsp_rdy` held low for 5 cycles in RESP: `rsp_vld` and `rsp_res` stay stable, no `req_rdy` asserts, and IDLE is entered the cycle after `rsp_rdy` rises.
- `rst` asserted in the 4th WAIT cycle: all outputs go to their reset values immediately. After release, the first grant waits until `mul_res_rdy`=1 and no stale response is issued.
- a=0, b=77 with `MULTIPLIER_ARBITER_ZERO_BYPASS_EN` defined: `rsp_vld` in T+1 with 0 and no `mul_in_vld` pulse. Without the macro: `rsp_vld` in T+11 with 0.
